// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the round-robin FIFO write-port arbiter.
// Pure declarations: no logic, no latency, no flow control.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int OW          = $clog2(NUM_REQ_DEF);

  // Index width for n producers; never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit at or after start, wrapping,
// optionally skipping one index. Zero latency, no flow control.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int OW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OW-1:0]      start,
  input  logic               exclude_en,
  input  logic [OW-1:0]      exclude_idx,
  output logic               found,
  output logic [OW-1:0]      idx
);

  logic [OW:0]   sum;
  logic [OW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, start} + (OW+1)'(k);
      if (sum >= (OW+1)'(NUM_REQ)) begin
        sum = sum - (OW+1)'(NUM_REQ);
      end
      cand = sum[OW-1:0];
      if (!found && req[cand] && !(exclude_en && (cand == exclude_idx))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter_rr.sv
// Round-robin owner of a shared FIFO write port, bursts of up to MAX_BURST words per grant.
// Grant one cycle after req in IDLE; fifo_wen is combinational from req/fifo_full, stalls hold all state.
module fifo_wr_arbiter_rr
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int MAX_BURST  = 4,
  localparam int CW         = $clog2(MAX_BURST + 1),
  localparam int OWD        = idx_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            accept,
  input  logic                          fifo_full,
  output logic                          fifo_wen,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [OWD-1:0]                owner,
  output logic                          busy
);

  state_t               state;
  logic [OWD-1:0]       owner_q;
  logic [OWD-1:0]       last_q;
  logic [CW-1:0]        cnt;
  logic [NUM_REQ-1:0]   gnt_q;

  logic                 in_burst;
  logic                 owner_req;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                 last_word;
  logic                 release_now;
  logic [OWD-1:0]       base;
  logic [OWD-1:0]       pick_start;
  logic                 pick_found;
  logic [OWD-1:0]       pick_idx;
  logic [NUM_REQ-1:0]   pick_oh;

  assign in_burst = (state == BURST);

  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    pick_oh    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OWD'(i)) begin
        owner_req  = req[i];
        owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      pick_oh[i] = (pick_idx == OWD'(i));
    end
  end

  assign fifo_wen    = in_burst && owner_req && !fifo_full;
  assign last_word   = fifo_wen && (cnt == CW'(MAX_BURST - 1));
  assign release_now = in_burst && (!owner_req || last_word);

  // In BURST the search starts after the owner and skips it; in IDLE it starts after last.
  assign base       = in_burst ? owner_q : last_q;
  assign pick_start = (base == OWD'(NUM_REQ - 1)) ? '0 : base + 1'b1;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OW      (OWD)
  ) u_pick (
    .req         (req),
    .start       (pick_start),
    .exclude_en  (in_burst),
    .exclude_idx (owner_q),
    .found       (pick_found),
    .idx         (pick_idx)
  );

  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      accept[i] = fifo_wen && (owner_q == OWD'(i));
    end
  end

  assign fifo_data = in_burst ? owner_data : '0;
  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign busy      = in_burst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner_q <= '0;
      last_q  <= OWD'(NUM_REQ - 1);
      cnt     <= '0;
      gnt_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            state   <= BURST;
            owner_q <= pick_idx;
            last_q  <= pick_idx;
            cnt     <= '0;
            gnt_q   <= pick_oh;
          end
        end
        BURST: begin
          if (release_now) begin
            if (pick_found) begin
              owner_q <= pick_idx;
              last_q  <= pick_idx;
              gnt_q   <= pick_oh;
              cnt     <= '0;
            end else if (owner_req) begin
              // Sole requester finished a full burst: re-grant to itself.
              cnt <= '0;
            end else begin
              state   <= IDLE;
              owner_q <= '0;
              gnt_q   <= '0;
              cnt     <= '0;
            end
          end else if (fifo_wen) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter_rr.sv
// Randomized bench for fifo_wr_arbiter_rr: producer streams and a FIFO occupancy model drive the DUT,
// a cycle-level arbitration model fills a scoreboard that an independent monitor drains.
module tb_fifo_wr_arbiter_rr;

  localparam int N          = 4;
  localparam int DW         = 16;
  localparam int MB         = 4;
  localparam int FIFO_DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  gnt;
  logic [N-1:0]  accept;
  logic          fifo_full = 1'b0;
  logic          fifo_wen;
  logic [DW-1:0] fifo_data;
  logic [1:0]    owner;
  logic          busy;

  fifo_wr_arbiter_rr #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .accept    (accept),
    .fifo_full (fifo_full),
    .fifo_wen  (fifo_wen),
    .fifo_data (fifo_data),
    .owner     (owner),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [1:0]    own;
    logic          wen;
    logic [DW-1:0] data;
  } rec_t;

  rec_t q[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic [N-1:0]  have = '0;
  logic [DW-1:0] word [N];
  int            seq [N];
  int            exp_seq [N];
  logic [N-1:0]  acc_prev = '0;
  logic          wen_prev = 1'b0;
  int            fcount = 0;

  // Arbitration model: -1 means nobody owns the port.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_n     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr(input logic [N-1:0] r, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic consume();
    for (int i = 0; i < N; i++) begin
      if (acc_prev[i]) have[i] = 1'b0;
    end
    if (wen_prev) fcount++;
  endtask

  task automatic step(input logic [N-1:0] mask, input int p_req, input int drain, input bit force_full);
    rec_t         r;
    logic [N-1:0] rq;
    logic         fl;
    bit           wr;
    int           cand;
    logic [N-1:0] one;
    @(posedge clk);
    #1;
    consume();
    if (fcount > 0 && $urandom_range(0, 99) < drain) fcount--;
    for (int i = 0; i < N; i++) begin
      if (!have[i] && mask[i]) begin
        word[i] = {2'(i), 14'(seq[i])};
        seq[i]++;
        have[i] = 1'b1;
      end
      rq[i] = have[i] && mask[i] && ($urandom_range(0, 99) < p_req);
      req_data[i*DW +: DW] = word[i];
    end
    fl        = force_full || (fcount >= FIFO_DEPTH);
    req       = rq;
    fifo_full = fl;

    one    = 4'b0001;
    r.gnt  = (m_owner < 0) ? '0 : one << m_owner;
    r.own  = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    wr     = (m_owner >= 0) && rq[m_owner] && !fl;
    r.wen  = wr;
    r.data = (m_owner < 0) ? '0 : word[m_owner];
    q.push_back(r);

    if (m_owner < 0) begin
      cand = rr(rq, (m_last + 1) % N, -1);
      if (cand >= 0) begin
        m_owner = cand;
        m_last  = cand;
        m_n     = 0;
      end
    end else begin
      if (wr) m_n++;
      if (!rq[m_owner] || (wr && m_n == MB)) begin
        cand = rr(rq, (m_owner + 1) % N, m_owner);
        if (cand >= 0) begin
          m_owner = cand;
          m_last  = cand;
        end else if (!rq[m_owner]) begin
          m_owner = -1;
        end
        m_n = 0;
      end
    end

    @(negedge clk);
    acc_prev = accept;
    wen_prev = fifo_wen;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_wen"}, 32'(fifo_wen), 32'd0);
    chk({tag, "_accept"}, 32'(accept), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_owner"}, 32'(owner), 32'd0);
    chk({tag, "_data"}, 32'(fifo_data), 32'd0);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #1;
    consume();
    acc_prev = '0;
    wen_prev = 1'b0;
    #1;
    req   = '0;
    reset = 1'b1;
    #1;
    reset_checks("midrst");
    m_owner = -1;
    m_last  = N - 1;
    m_n     = 0;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    rec_t r;
    int   id;
    if (!reset) begin
      if (q.size() > 0) begin
        r = q.pop_front();
        chk("gnt", 32'(gnt), 32'(r.gnt));
        chk("busy", 32'(busy), 32'(r.gnt != '0));
        chk("owner", 32'(owner), 32'(r.own));
        chk("wen", 32'(fifo_wen), 32'(r.wen));
        chk("accept", 32'(accept), r.wen ? 32'(r.gnt) : 32'd0);
        chk("data", 32'(fifo_data), 32'(r.data));
      end else begin
        chk("unscheduled_wen", 32'(fifo_wen), 32'd0);
      end
      if (fifo_wen) begin
        chk("overrun", 32'(fifo_full), 32'd0);
        id = int'(fifo_data[15:14]);
        chk("stream_seq", 32'(fifo_data[13:0]), 32'(14'(exp_seq[id])));
        exp_seq[id]++;
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      word[i]    = '0;
      seq[i]     = 0;
      exp_seq[i] = 0;
    end
    #1 reset = 1'b1;
    #11;
    reset_checks("reset");
    @(negedge clk);
    #1 reset = 1'b0;

    // All producers busy, FIFO drained every cycle: 0,1,2,3,0 rotation.
    repeat (24) step(4'hF, 100, 100, 1'b0);
    // Sole requester re-granted without gaps.
    repeat (12) step(4'b0100, 100, 100, 1'b0);
    // Full stall in mid-burst.
    repeat (3) step(4'hF, 100, 100, 1'b0);
    repeat (5) step(4'hF, 100, 100, 1'b1);
    repeat (8) step(4'hF, 100, 100, 1'b0);
    // Async reset partway through a burst, then 0101 must start at producer 0.
    repeat (11) step(4'hF, 100, 100, 1'b0);
    reset_mid();
    repeat (12) step(4'b0101, 100, 100, 1'b0);
    // Random requests and drops against a slowly drained 16-entry FIFO.
    repeat (600) step(4'($urandom_range(0, 15)), 70, 30, ($urandom_range(0, 9) == 0));
    repeat (300) step(4'hF, 90, 60, 1'b0);
    repeat (4) step(4'h0, 0, 100, 1'b0);

    #2;
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter_rr.md
# fifo_wr_arbiter_rr

Round-robin write-port arbiter that shares one single-clock register-array FIFO between `NUM_REQ` producers. Each granted producer owns the FIFO write port for a burst of up to `MAX_BURST` words, then ownership rotates. The arbiter sits between the producer blocks and the FIFO `wen`/`data_in`/`full` pins. Back-pressure comes from FIFO `full`.

## Interface
- `NUM_REQ`, 4: number of producers, at least 2.
- `DATA_WIDTH`, 16: word width, matching the FIFO.
- `MAX_BURST`, 4: maximum number of words written per grant, at least 1.
- `CW`, `$clog2(MAX_BURST+1)`: burst counter width (derived, not overridden).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in NUM_REQ: producer `i` has a word valid on its data slice.
- `req_data` in NUM_REQ*DATA_WIDTH: flat bus; slice `i` is `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `gnt` out NUM_REQ: registered one-hot owner; all zero when idle.
- `accept` out NUM_REQ: one-hot; producer `i`'s word is consumed this cycle.
- `fifo_full` in 1: FIFO `full`.
- `fifo_wen` out 1: to FIFO `wen`.
- `fifo_data` out DATA_WIDTH: to FIFO `data_in`.
- `owner` out `$clog2(NUM_REQ)`: index of the current owner; 0 when idle.
- `busy` out 1: high in BURST.

## Operation
- Two states:
  - IDLE: no owner.
  - BURST: one owner, held in `owner_q`.
- Round-robin pick:
  - Search `req` starting at `(last+1) mod NUM_REQ` and wrap; the first set bit wins.
  - `last` is the index of the most recent owner.
- IDLE → BURST when `|req`:
  - Load `owner_q` with the winner and `last` with the winner.
  - Clear `cnt`.
  - Set `gnt` to the winner's one-hot.
- In BURST:
  - `fifo_wen = req[owner_q] & ~fifo_full`.
  - `accept = fifo_wen ? onehot(owner_q) : 0`.
  - `fifo_data` = slice `owner_q` of `req_data`, driven whenever in BURST.
  - `cnt` increments on each `fifo_wen`.
- Release from BURST happens when either condition holds:
  - `req[owner_q]` is 0.
  - `fifo_wen & (cnt == MAX_BURST-1)`.
- On release:
  - If any other producer requests, pick the next owner from `(owner_q+1)`, excluding the current owner, and stay in BURST with `cnt` cleared.
  - If no other producer requests, go to IDLE and clear `gnt`.
- A sole requester is re-granted after a full burst: with only one requester, the pick falls back to `owner_q` itself.
- `fifo_full` stall: `cnt`, `owner_q` and `gnt` hold, and there is no timeout. A requester that drops `req` during a stall releases the grant.
- Outputs are never X. When idle: `fifo_wen = 0`, `accept = 0`, `fifo_data = 0`.

## Timing
- Reset values (asynchronous):
  - state = IDLE; `gnt`, `accept`, `fifo_wen`, `busy`, `owner` = 0.
  - `cnt` = 0; `last` = NUM_REQ-1, so producer 0 has priority first.
- Grant latency: `req` rising in IDLE gives `gnt` on the next edge. The first `fifo_wen` is in that same cycle if not full, i.e. 1 cycle from request to first write.
- Back-to-back handoff: the new owner's first write is in the cycle after the old owner's last write, with no dead cycle.
- Peak throughput: one word per cycle.
- The FIFO sees `fifo_wen` combinationally from `req` and `fifo_full`. There is no pipeline register, so the FIFO must not be overrun.
- A producer changes its data slice only after the cycle in which its `accept` is high.
- Reset asserted mid-burst: all state clears immediately. Any word not accepted is not written.

## Structure
- Package `fifo_arb_pkg`:
  - state type (IDLE, BURST).
  - localparams for `OW = $clog2(NUM_REQ)`.
- Sub-module `rr_pick`: purely combinational.
  - Inputs `req`, `start`, `exclude_en`, `exclude_idx`.
  - Outputs `found`, `idx`.
- Top level: state register, counter, output mux.

## Test plan
- Reset with `req=4'b1111`, `MAX_BURST=4`, never full. Expected grant sequence: 0,1,2,3,0, with exactly 4 writes each, 20 `fifo_wen` in 20 cycles, and `fifo_data` equal to the owner's words in order.
- Single `req=4'b0100` held 10 cycles. Expected: `gnt=4'b0100` throughout, re-granted after each 4 words, 10 writes, no idle gap.
- Owner 1 drops `req` after 2 words while `req[3]=1`. Expected: the next cycle has `gnt=4'b1000`, `cnt=0`, and producer 3's write.
- `fifo_full=1` for 5 cycles mid-burst at `cnt=2`. Expected: `fifo_wen=0`, `accept=0`, `gnt` and `cnt` unchanged; 2 remaining writes after `full` drops.
- `reset` pulsed at word 3 of owner 2's burst. Expected: `gnt=0` and `fifo_wen=0` asynchronously; after release with `req=4'b0101`, owner 0 wins first.
- Drive the FIFO to full with `ADDR_WIDTH=4`. Expected: the FIFO never sees `wen` while `full`, and the scoreboard shows no lost or duplicated words.
